// File: rtl/dram_sram_resp_pkg.sv
// Shared widths, the response-FIFO entry layout and the byte-lane merge
// helper for the data-RAM responder.
package dram_sram_resp_pkg;

    localparam int XLEN         = 32;
    localparam int DRAM_WSTRB_W = 4;
    // Countdown wide enough for the largest supported latency (7).
    localparam int CD_W         = 3;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [CD_W-1:0] cd;
    } resp_entry_t;

    function automatic logic [XLEN-1:0] wstrb_merge(
        input logic [XLEN-1:0]         old_word,
        input logic [XLEN-1:0]         new_word,
        input logic [DRAM_WSTRB_W-1:0] wstrb
    );
        logic [XLEN-1:0] merged;
        merged = old_word;
        for (int b = 0; b < DRAM_WSTRB_W; b++) begin
            if (wstrb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dram_sram_resp_if.sv
// Data memory request/response bus between the core (master) and the
// data-RAM responder (slave).
interface dram_sram_resp_if;
    import dram_sram_resp_pkg::*;

    logic                    dram_req;
    logic                    dram_write;
    logic [XLEN-1:0]         dram_addr;
    logic [DRAM_WSTRB_W-1:0] dram_wstrb;
    logic [XLEN-1:0]         dram_wdata;
    logic                    dram_addr_ok;
    logic                    dram_data_ok;
    logic [XLEN-1:0]         dram_rdata;
    logic                    dram_resp_ack;
    logic                    dram_flush;

    modport master (
        output dram_req, dram_write, dram_addr, dram_wstrb, dram_wdata,
               dram_resp_ack, dram_flush,
        input  dram_addr_ok, dram_data_ok, dram_rdata
    );

    modport slave (
        input  dram_req, dram_write, dram_addr, dram_wstrb, dram_wdata,
               dram_resp_ack, dram_flush,
        output dram_addr_ok, dram_data_ok, dram_rdata
    );

endinterface

// File: rtl/dram_sram_array.sv
// Behavioural 1R/1W word array with byte-strobed synchronous write and
// asynchronous read; a vendor macro can take its place.
module dram_sram_array
    import dram_sram_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  logic [DRAM_WSTRB_W-1:0]        wstrb,
    input  logic [XLEN-1:0]                wdata,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    output logic [XLEN-1:0]                rdata
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wstrb_merge(mem[waddr], wdata, wstrb);
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dram_sram_resp.sv
// Data-RAM responder: commits stores to the array and returns load data
// through an in-order response FIFO with per-entry latency countdowns.
module dram_sram_resp
    import dram_sram_resp_pkg::*;
#(
    parameter int DEPTH_WORDS     = 1024,
    parameter int LATENCY         = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic             clk,
    input logic             rst_b,
    dram_sram_resp_if.slave bus
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CD_W-1:0]  CD_INIT = CD_W'(LATENCY - 1);

    logic [CNT_W-1:0]           rd_cnt;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [MAX_OUTSTANDING-1:0] vld;
    resp_entry_t                fifo [MAX_OUTSTANDING];
    resp_entry_t                head;
    logic                       accept;
    logic                       rd_accept;
    logic                       store_we;
    logic                       pop;
    logic [XLEN-1:0]            arr_rdata;
    logic [AW-1:0]              word_idx;
    logic                       unused_addr_bits;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Byte offset and bits above the array size are dropped, so addresses wrap.
    assign word_idx         = bus.dram_addr[AW+1:2];
    assign unused_addr_bits = ^{bus.dram_addr[1:0], bus.dram_addr[XLEN-1:AW+2]};

    assign head             = fifo[rd_ptr];
    assign bus.dram_addr_ok = rst_b & ~bus.dram_flush & (rd_cnt < MAX_CNT);
    assign bus.dram_data_ok = vld[rd_ptr] & (head.cd == '0);
    assign bus.dram_rdata   = bus.dram_data_ok ? head.data : '0;

    assign accept    = bus.dram_req & bus.dram_addr_ok;
    assign rd_accept = accept & ~bus.dram_write;
    assign store_we  = accept & bus.dram_write;
    // Flush outranks ack: a flushed head is discarded, not popped.
    assign pop       = bus.dram_data_ok & bus.dram_resp_ack & ~bus.dram_flush;

    dram_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (store_we),
        .waddr (word_idx),
        .wstrb (bus.dram_wstrb),
        .wdata (bus.dram_wdata),
        .raddr (word_idx),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rd_cnt <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld    <= '0;
        end else if (bus.dram_flush) begin
            rd_cnt <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld    <= '0;
        end else begin
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= ptr_inc(rd_ptr);
            end
            if (rd_accept) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            rd_cnt <= rd_cnt + CNT_W'(rd_accept) - CNT_W'(pop);
        end
    end

    // Entry payload carries no reset; validity alone decides presentation.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (fifo[i].cd != '0) fifo[i].cd <= fifo[i].cd - CD_W'(1);
        end
        if (rd_accept) fifo[wr_ptr] <= '{data: arr_rdata, cd: CD_INIT};
    end

endmodule

// File: tb/tb_dram_sram_resp.sv
// Directed and randomized bench for dram_sram_resp, run on two parameter sets
// against a queue-based reference model.
module tb_dram_sram_resp;

    localparam int DW_A = 1024, LAT_A = 1, MO_A = 2;
    localparam int DW_B = 64,   LAT_B = 3, MO_B = 4;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    dram_sram_resp_if bus_a ();
    dram_sram_resp_if bus_b ();

    logic        req_v  [2];
    logic        wr_v   [2];
    logic [31:0] addr_v [2];
    logic [3:0]  st_v   [2];
    logic [31:0] wd_v   [2];
    logic        ack_v  [2];
    logic        fl_v   [2];

    assign bus_a.dram_req      = req_v[0];
    assign bus_a.dram_write    = wr_v[0];
    assign bus_a.dram_addr     = addr_v[0];
    assign bus_a.dram_wstrb    = st_v[0];
    assign bus_a.dram_wdata    = wd_v[0];
    assign bus_a.dram_resp_ack = ack_v[0];
    assign bus_a.dram_flush    = fl_v[0];
    assign bus_b.dram_req      = req_v[1];
    assign bus_b.dram_write    = wr_v[1];
    assign bus_b.dram_addr     = addr_v[1];
    assign bus_b.dram_wstrb    = st_v[1];
    assign bus_b.dram_wdata    = wd_v[1];
    assign bus_b.dram_resp_ack = ack_v[1];
    assign bus_b.dram_flush    = fl_v[1];

    dram_sram_resp #(.DEPTH_WORDS(DW_A), .LATENCY(LAT_A), .MAX_OUTSTANDING(MO_A)) dut_a (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus_a)
    );

    dram_sram_resp #(.DEPTH_WORDS(DW_B), .LATENCY(LAT_B), .MAX_OUTSTANDING(MO_B)) dut_b (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus_b)
    );

    // Reference model: word memory per DUT plus one queue of pending loads.
    typedef struct {
        int          d;
        logic [31:0] data;
        int          t;
    } resp_t;

    resp_t       q [$];
    logic [31:0] mmem [2][1024];
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;
    logic        eok  [2];
    logic        edok [2];
    logic [31:0] erd  [2];

    function automatic int lat(int d); return (d == 0) ? LAT_A : LAT_B; endfunction
    function automatic int mo(int d);  return (d == 0) ? MO_A  : MO_B;  endfunction
    function automatic int dw(int d);  return (d == 0) ? DW_A  : DW_B;  endfunction

    function automatic int widx(int d, logic [31:0] a);
        return int'(a >> 2) % dw(d);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    function automatic int head_of(int d);
        foreach (q[i]) if (q[i].d == d) return i;
        return -1;
    endfunction

    function automatic int count_of(int d);
        int n = 0;
        foreach (q[i]) if (q[i].d == d) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(int d, logic req, logic wr, logic [31:0] addr, logic [3:0] st,
                         logic [31:0] wd, logic ack, logic fl);
        req_v[d] = req; wr_v[d] = wr; addr_v[d] = addr; st_v[d] = st;
        wd_v[d] = wd; ack_v[d] = ack; fl_v[d] = fl;
    endtask

    task automatic idle(int d, logic ack);
        drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, ack, 1'b0);
    endtask

    task automatic expect_outputs();
        for (int d = 0; d < 2; d++) begin
            int h;
            h = head_of(d);
            eok[d]  = rst_b && !fl_v[d] && (count_of(d) < mo(d));
            edok[d] = 1'b0;
            erd[d]  = 32'h0;
            if (rst_b && h >= 0 && cyc >= q[h].t + lat(d)) begin
                edok[d] = 1'b1;
                erd[d]  = q[h].data;
            end
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        @(negedge clk);
        expect_outputs();
        chk("addr_ok_a", 32'(bus_a.dram_addr_ok), 32'(eok[0]));
        chk("data_ok_a", 32'(bus_a.dram_data_ok), 32'(edok[0]));
        chk("rdata_a",   bus_a.dram_rdata,        erd[0]);
        chk("addr_ok_b", 32'(bus_b.dram_addr_ok), 32'(eok[1]));
        chk("data_ok_b", 32'(bus_b.dram_data_ok), 32'(edok[1]));
        chk("rdata_b",   bus_b.dram_rdata,        erd[1]);
        @(posedge clk);
        if (rst_b) begin
            for (int d = 0; d < 2; d++) begin
                if (fl_v[d]) begin
                    for (int i = q.size() - 1; i >= 0; i--) if (q[i].d == d) q.delete(i);
                end else begin
                    if (ack_v[d] && edok[d]) q.delete(head_of(d));
                    if (req_v[d] && eok[d]) begin
                        if (wr_v[d])
                            mmem[d][widx(d, addr_v[d])] = merge(mmem[d][widx(d, addr_v[d])], wd_v[d], st_v[d]);
                        else
                            q.push_back('{d: d, data: mmem[d][widx(d, addr_v[d])], t: cyc});
                    end
                end
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        rst_b = 1'b0;
        idle(0, 1'b0);
        idle(1, 1'b0);
        @(posedge clk);
        #1;

        // Reset held: everything quiet.
        chk("rst_addr_ok", 32'(bus_a.dram_addr_ok), 32'h0);
        chk("rst_data_ok", 32'(bus_a.dram_data_ok), 32'h0);
        chk("rst_rdata",   bus_a.dram_rdata,        32'h0);
        for (int i = 0; i < 3; i++) step();
        rst_b = 1'b1;
        #1;
        chk("rel_addr_ok_a", 32'(bus_a.dram_addr_ok), 32'h1);
        chk("rel_addr_ok_b", 32'(bus_b.dram_addr_ok), 32'h1);
        step();

        // Give every word a known value.
        for (int i = 0; i < DW_A; i++) begin
            drive(0, 1'b1, 1'b1, 32'(i * 4), 4'hF, $urandom, 1'b0, 1'b0);
            if (i < DW_B) drive(1, 1'b1, 1'b1, 32'(i * 4), 4'hF, $urandom, 1'b0, 1'b0);
            else          idle(1, 1'b0);
            step();
        end
        idle(1, 1'b0);

        // Store then load, then a partial store.
        drive(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
        step();
        drive(0, 1'b1, 1'b0, 32'h12, 4'h0, 32'h0, 1'b0, 1'b0);
        step();
        idle(0, 1'b1);
        #1;
        chk("sl_data_ok", 32'(bus_a.dram_data_ok), 32'h1);
        chk("sl_rdata",   bus_a.dram_rdata,        32'hDEADBEEF);
        step();
        drive(0, 1'b1, 1'b1, 32'h10, 4'h1, 32'h000000AA, 1'b0, 1'b0);
        step();
        drive(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0);
        step();
        idle(0, 1'b1);
        #1;
        chk("partial_rdata", bus_a.dram_rdata, 32'hDEADBEAA);
        step();

        // Backpressure with two outstanding and no ack.
        drive(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 1'b0);
        step();
        drive(0, 1'b1, 1'b0, 32'h24, 4'h0, 32'h0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, 1'b0, 32'h28, 4'h0, 32'h0, 1'b0, 1'b0);
            #1;
            chk("bp_addr_ok", 32'(bus_a.dram_addr_ok), 32'h0);
            chk("bp_hold",    bus_a.dram_rdata,        mmem[0][8]);
            step();
        end
        drive(0, 1'b1, 1'b0, 32'h28, 4'h0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("bp_ack_addr_ok", 32'(bus_a.dram_addr_ok), 32'h0);
        step();
        drive(0, 1'b1, 1'b0, 32'h28, 4'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("bp_third_ok", 32'(bus_a.dram_addr_ok), 32'h1);
        chk("bp_second",   bus_a.dram_rdata,        mmem[0][9]);
        step();
        idle(0, 1'b1);
        for (int i = 0; i < 3; i++) step();

        // Flush with two pending, plus ack and a new request in the same cycle.
        drive(0, 1'b1, 1'b1, 32'h40, 4'hF, 32'h5A5A1234, 1'b0, 1'b0);
        step();
        drive(0, 1'b1, 1'b0, 32'h48, 4'h0, 32'h0, 1'b0, 1'b0);
        step();
        drive(0, 1'b1, 1'b0, 32'h4C, 4'h0, 32'h0, 1'b0, 1'b0);
        step();
        drive(0, 1'b1, 1'b0, 32'h50, 4'h0, 32'h0, 1'b1, 1'b1);
        #1;
        chk("fl_addr_ok", 32'(bus_a.dram_addr_ok), 32'h0);
        step();
        idle(0, 1'b0);
        #1;
        chk("fl_data_ok", 32'(bus_a.dram_data_ok), 32'h0);
        drive(0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("fl_cnt0_ok", 32'(bus_a.dram_addr_ok), 32'h1);
        step();
        #1;
        chk("fl_cnt1_ok", 32'(bus_a.dram_addr_ok), 32'h1);
        step();
        idle(0, 1'b1);
        #1;
        chk("fl_store_kept", bus_a.dram_rdata, 32'h5A5A1234);
        for (int i = 0; i < 3; i++) step();

        // Streaming at latency 3 with four outstanding and aliased addresses.
        for (int i = 0; i < 15; i++) begin
            drive(1, i < 10, 1'b0, 32'(32'h1000 + (i % 3) * 4 * DW_B + i * 4), 4'h0, 32'h0, 1'b1, 1'b0);
            #1;
            if (i < 10) chk("st_addr_ok", 32'(bus_b.dram_addr_ok), 32'h1);
            if (i < 3) begin
                chk("st_early", 32'(bus_b.dram_data_ok), 32'h0);
            end else if (i < 13) begin
                chk("st_data_ok", 32'(bus_b.dram_data_ok), 32'h1);
                chk("st_rdata",   bus_b.dram_rdata,        mmem[1][i-3]);
            end
            step();
        end
        drive(1, 1'b1, 1'b1, 32'h2008, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0);
        step();
        drive(1, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 1'b0, 1'b0);
        step();
        idle(1, 1'b1);
        step();
        step();
        #1;
        chk("alias_rdata", bus_b.dram_rdata, 32'hCAFEF00D);
        step();

        // Randomized traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 2; d++) begin
                drive(d, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                      32'($urandom_range(0, 16 * dw(d) - 1)), 4'($urandom), $urandom,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
            end
            step();
        end
        idle(0, 1'b1);
        idle(1, 1'b1);
        for (int i = 0; i < 8; i++) step();

        // Asynchronous reset while a response is presented.
        drive(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0);
        step();
        idle(0, 1'b0);
        #1;
        chk("ar_before", 32'(bus_a.dram_data_ok), 32'h1);
        #1;
        rst_b = 1'b0;
        #1;
        chk("ar_data_ok", 32'(bus_a.dram_data_ok), 32'h0);
        chk("ar_rdata",   bus_a.dram_rdata,        32'h0);
        chk("ar_addr_ok", 32'(bus_a.dram_addr_ok), 32'h0);
        q.delete();
        step();
        rst_b = 1'b1;
        idle(0, 1'b1);
        for (int i = 0; i < 4; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
